// File: rtl/cic_interpolator.sv
// CIC interpolator: N low-rate combs, zero-stuff by R, N high-rate integrators.
// Low-rate samples enter via valid/ready; one output per enabled cycle.
module cic_interpolator #(
    parameter int N         = 3,
    parameter int R         = 4,
    parameter int M         = 1,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 22
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    output logic                        underrun
);

    localparam int W  = IN_WIDTH + N * $clog2(R * M);
    localparam int PW = $clog2(R);

    logic [PW-1:0]       phase;
    logic                slot;
    logic                fire;
    logic signed [W-1:0] dly [N][M];
    logic signed [W-1:0] comb_sig [N+1];
    logic signed [W-1:0] stuff;
    logic signed [W-1:0] integ [N];
    logic [N:0]          prime_sr;

    assign slot     = enable && (phase == '0);
    assign in_ready = slot && reset;
    assign fire     = in_valid && in_ready;

    // A missed slot feeds zero into the combs rather than stale data.
    always_comb begin
        comb_sig[0] = '0;
        if (in_valid) begin
            comb_sig[0] = {{(W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        end
        for (int k = 0; k < N; k++) begin
            comb_sig[k+1] = comb_sig[k] - dly[k][M-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (enable) begin
            if (phase == PW'(R - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < M; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else if (slot) begin
            for (int k = 0; k < N; k++) begin
                dly[k][0] <= comb_sig[k];
                for (int j = 1; j < M; j++) begin
                    dly[k][j] <= dly[k][j-1];
                end
            end
        end
    end

    // Integrators wrap modulo 2^W; the combs undo the wrap exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuff    <= '0;
            out_data <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else if (enable) begin
            stuff    <= (phase == '0) ? comb_sig[N] : '0;
            integ[0] <= integ[0] + stuff;
            for (int k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
            out_data <= integ[N-1][W-1 -: OUT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_sr  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (enable) begin
                prime_sr <= {prime_sr[N-1:0], prime_sr[0] | fire};
            end
            out_valid <= enable && prime_sr[N];
            underrun  <= slot && !in_valid;
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator at N=3, R=4, M=1, 16-bit in, 22-bit out.
// Expected values are the hand-derived impulse response 1,3,6,10,12,12,10,6,3,1.
module tb_cic_interpolator;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [21:0] out_data;
    logic               out_valid;
    logic               underrun;

    int checks;
    int failures;
    int ph;
    logic rdy_seen;
    int exp_imp [0:20];

    cic_interpolator #(
        .N(3), .R(4), .M(1), .IN_WIDTH(16), .OUT_WIDTH(22)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Drive one cycle; afterwards we sit 1 time unit into the next cycle.
    task automatic cyc(input logic en, input logic v, input logic signed [15:0] d);
        enable   = en;
        in_valid = v;
        in_data  = d;
        #1;
        rdy_seen = in_ready;
        @(posedge clk);
        #1;
        if (en) ph = (ph + 1) % 4;
    endtask

    task automatic run_impulse(input logic fresh);
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 1'b1, (c == 0) ? 16'sd1 : 16'sd0);
            if (c < 8) chk("imp_rdy", rdy_seen, (c % 4) == 0);
            chk("imp_out", out_data, exp_imp[c+1]);
            if (fresh) chk("imp_vld", out_valid, (c + 1) >= 5);
            chk("imp_unr", underrun, 0);
        end
    endtask

    task automatic align();
        while (ph != 0) cyc(1'b1, 1'b1, 16'sd0);
    endtask

    initial begin
        int e;
        checks   = 0;
        failures = 0;
        ph       = 0;
        for (int i = 0; i <= 20; i++) exp_imp[i] = 0;
        exp_imp[5]  = 1;  exp_imp[6]  = 3;  exp_imp[7]  = 6;
        exp_imp[8]  = 10; exp_imp[9]  = 12; exp_imp[10] = 12;
        exp_imp[11] = 10; exp_imp[12] = 6;  exp_imp[13] = 3;
        exp_imp[14] = 1;

        reset    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'sd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out", out_data, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_unr", underrun, 0);
        chk("rst_rdy", in_ready, 0);
        reset = 1'b1;

        run_impulse(1'b1);

        for (int c = 0; c < 28; c++) cyc(1'b1, 1'b1, 16'sd100);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 1'b1, 16'sd100);
            chk("dc100", out_data, 1600);
        end

        for (int c = 0; c < 28; c++) cyc(1'b1, 1'b1, -16'sd32768);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 1'b1, -16'sd32768);
            chk("dcneg", out_data, -524288);
        end

        for (int c = 0; c < 28; c++) cyc(1'b1, 1'b1, 16'sd0);
        chk("drain", out_data, 0);
        align();

        for (int c = 0; c < 24; c++) begin
            cyc(1'b1, c != 0, (c == 0) ? 16'sd5 : ((c == 4) ? 16'sd1 : 16'sd0));
            if (c == 0 || c == 4) chk("unr_rdy", rdy_seen, 1);
            chk("unr_pulse", underrun, c == 0);
            chk("unr_out", out_data, (c >= 3) ? exp_imp[c-3] : 0);
            chk("unr_vld", out_valid, 1);
        end
        align();

        e = 0;
        for (int c = 0; c < 40; c++) begin
            logic en;
            en = (c % 2) == 0;
            cyc(en, 1'b1, (en && e == 0) ? 16'sd1 : 16'sd0);
            chk("gate_rdy", rdy_seen, en && (e % 4) == 0);
            if (en) begin
                e++;
                chk("gate_vld", out_valid, 1);
            end else begin
                chk("gate_idle", out_valid, 0);
            end
            chk("gate_out", out_data, exp_imp[e]);
        end
        align();

        for (int c = 0; c < 26; c++) cyc(1'b1, 1'b1, 16'sd100);
        chk("pre_rst", out_data, 1600);
        enable   = 1'b1;
        in_valid = 1'b1;
        reset    = 1'b0;
        #1;
        chk("mid_out", out_data, 0);
        chk("mid_vld", out_valid, 0);
        chk("mid_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ph    = 0;
        run_impulse(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Multi-stage CIC interpolator. It is the transmit-side counterpart of the CIC decimator's comb/integrator chain. It accepts low-rate samples through a valid/ready handshake and runs N comb stages at the low rate. It then zero-stuffs by R and runs N integrator stages at the high (clock-enable) rate, producing one output sample per enabled cycle. It sits between the resolver excitation/reference sample generator and the DAC-rate datapath.

## Interface
- N, 3, number of comb and integrator stages (1..6)
- R, 4, interpolation ratio (2..64)
- M, 1, differential delay per comb stage (1 or 2)
- IN_WIDTH, 16, signed input width
- OUT_WIDTH, 22, signed output width; must be ≤ W
- Internal width W = IN_WIDTH + N*$clog2(R*M), derived and not overridable
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; clears all state
- enable  in  1  high-rate clock enable; all state advances only when high
- in_data  in  IN_WIDTH  signed low-rate sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a sample this cycle
- out_data  out  OUT_WIDTH  signed interpolated sample
- out_valid  out  1  out_data updated this cycle
- underrun  out  1  one-cycle pulse: input slot missed

## Operation
- Phase counter 0..R-1 advances on every enable cycle and wraps R-1→0.
- in_ready = enable && phase==0. The handshake fires when in_valid && in_ready.
- Slot with in_valid low at phase 0 and enable high:
  - a zero sample is pushed through the combs;
  - underrun pulses high in the next cycle.
- Comb section: N cascaded stages, each y = x − x[n−M]. Delay lines are M deep at W bits, sign-extended from IN_WIDTH.
  - Comb delay lines advance only on slot cycles (phase 0 with enable).
  - The comb chain is combinational between the input and the stuffer register.
- Stuffer register, updated on enable:
  - loads the comb output at phase 0;
  - loads 0 at phases 1..R-1.
- Integrator section: N registered stages, each acc <= acc + prev, updated on enable.
- Arithmetic: all W-bit two's complement, modular.
  - Integrator overflow wraps silently and is required; there is no saturation.
- out_data register, updated on enable: integrator N bits [W-1 : W-OUT_WIDTH] (truncation, no rounding).
- out_valid pipeline:
  - out_valid = enable delayed one cycle, gated by a primed flag.
  - The primed flag sets N+1 enable cycles after the first handshake and stays set until reset.
- Reset values: phase=0, all comb/integrator/stuffer registers 0, out_data=0, out_valid=0, underrun=0, in_ready=0 while reset is asserted, primed=0.
- Reset mid-operation clears everything asynchronously. Processing restarts at phase 0 after release.
- With enable low: nothing advances, in_ready=0, out_valid=0, and the underrun check does not occur.
- Simultaneous slot and reset: reset wins.

## Timing
- With enable held high, take a sample accepted in cycle t:
  - stuffer holds its comb result in cycle t+1;
  - integrator k holds its contribution in cycle t+1+k;
  - out_data reflects it in cycle t+N+2.
- Latency is N+2 enabled cycles.
- Throughput: one input per R enabled cycles, one output per enabled cycle.
- in_ready is combinational from phase and enable. It does not depend on in_valid.
- DC gain is (R*M)^N / R before truncation.

## Test plan
- Impulse response, N=1, R=4, M=1, OUT_WIDTH=W, enable=1:
  - stimulus: in_data 1 then 0s;
  - response: out_data 1,1,1,1 then 0s, starting 3 cycles after acceptance (zero-order hold).
- DC gain, N=3, R=4, M=1, IN_WIDTH=16, OUT_WIDTH=22:
  - stimulus: constant 100;
  - response: out_data settles at exactly 1600.
- Negative full-scale DC, same config:
  - stimulus: constant −32768;
  - response: settles at −524288. Integrator wrap is exercised and the output is correct.
- Underrun, any config:
  - stimulus: in_valid low at one phase-0 slot;
  - response: underrun pulses once, the slot is treated as 0, and the next slot's handshake is unaffected.
- Enable gating:
  - stimulus: enable toggled 1010…;
  - response: outputs identical to the continuous run with idle cycles removed; out_valid only follows enabled cycles.
- Mid-stream reset:
  - stimulus: reset asserted for 1 cycle at phase 2;
  - response: out_data=0, out_valid=0 and in_ready=0 immediately. After release, in_ready rises at the first enabled cycle and the impulse test reproduces exactly.
